mux16_rr_arbiter: RTL
=====================

# mux16_rr_arbiter

Round-robin arbiter that shares one 16:1 gate-level data multiplexer among 16 requesters. It drives the mux's 4-bit select and a one-hot grant vector from registered state. It sits directly in front of the `mux_16x1` select inputs. Optionally, it bounds how long any requester may hold the mux.

## Interface
- `MAX_HOLD`, 8: maximum consecutive cycles one grant may be held. Range 1..255. Used only when the timeout feature is compiled in.
- `clk  input  1`: sole clock; all state updates on the rising edge.
- `rst  input  1`: synchronous, active-high reset.
- `req  input  16`: request lines; `req[i]` high means requester i wants the mux. A requester holds it high for as long as it needs the mux.
- `gnt  output  16`: one-hot grant, registered; all zeros when no grant.
- `sel  output  4`: registered mux select; equals the index of the set bit of `gnt`.
- `valid  output  1`: registered; high exactly when `gnt` is nonzero. The mux output is meaningful only while `valid` is high.

## Operation
- **State:**
  - FSM has two states, IDLE and BUSY.
  - `last`, 4 bits: index of the most recent grant.
  - `hold_cnt`, 8 bits.
- **Reset values:** `gnt`=0, `sel`=0, `valid`=0, `last`=15 (so the first search starts at index 0), `hold_cnt`=0, state IDLE.
- **Round-robin pick:**
  - Search `req` starting at index `last`+1 and wrapping modulo 16 (15 wraps to 0).
  - The first set bit found wins. Priority is purely positional within that rotation.
- **IDLE:**
  - If `req` is zero, stay in IDLE; outputs stay zero.
  - Otherwise, go to BUSY with `gnt`/`sel` set to the pick, `valid`=1, `last` = pick, `hold_cnt`=1.
- **BUSY, grant end:** the grant ends when either of these is true:
  - `req[sel]` is 0, or
  - the timeout fires (see Configuration).
- **BUSY, grant continues:** if the grant has not ended, outputs stay unchanged and `hold_cnt` increments, saturating at 255.
- **BUSY, grant ends:** re-arbitrate in the same cycle, with `last` already equal to the current holder.
  - If another requester is pending, switch to it directly with no idle bubble. `hold_cnt` becomes 1.
  - If no requester is pending, go to IDLE and clear the outputs.
  - Timeout while the holder is the only requester: the holder is re-granted and `hold_cnt` becomes 1. It is never starved.
- **Invariants:**
  - `gnt` is always zero or one-hot.
  - `sel` never changes while `valid`=1 unless `gnt` changes in the same cycle.

## Timing
- Latency from a request to its grant is 1 cycle. A `req` bit sampled at edge t produces `gnt`/`valid` after edge t.
- Release latency is 1 cycle. `req[sel]` dropped before edge t makes `gnt` change after edge t.
- Handover to the next requester happens on that same edge.
- Simultaneous requests arriving in one cycle are resolved purely by the rotation order from `last`+1.
- A requester that drops `req` and re-asserts it in the next cycle is treated as a new request and waits for its turn in the rotation.
- Reset asserted mid-grant clears every output and all state on the next edge, regardless of `req`. Arbitration resumes the cycle after `rst` deasserts, starting the search at index 0.
- All outputs are registered; there is no combinational path from `req` to any output.

## Configuration
- The macro `MUX16_ARB_TIMEOUT_EN` controls the hold timeout.
- Defined: the grant ends when `hold_cnt` = `MAX_HOLD` at a rising edge, even if `req[sel]` is still high. Arbitration then proceeds as described in Operation.
- Undefined:
  - No timeout; a grant lasts until `req[sel]` falls.
  - `hold_cnt` is still maintained for debug, with the same saturating behaviour.
  - `MAX_HOLD` is ignored.

## Test plan
- **Reset and first request:** assert `rst` with `req`=16'hFFFF.
  - During reset and for the reset cycle, all outputs are 0.
  - After `rst` falls, the first grant is `sel`=0, `gnt`=16'h0001 one cycle later.
- **Rotation:** hold `req`=16'h8421 and drop each granted bit for one cycle after 2 cycles of holding.
  - Grant order is 0, 5, 10, 15, 0, with no idle bubble between grants.
- **Wrap:** `last`=14 and `req`=16'h0003.
  - The next grant is index 0, then index 1. Index 15 is never selected.
- **Timeout** (`MUX16_ARB_TIMEOUT_EN`, `MAX_HOLD`=4), with `req`=16'h0006 held constant.
  - Requester 1 is granted for 4 cycles, then requester 2 for 4 cycles, alternating.
  - With `req`=16'h0002 only, requester 1 stays granted continuously with `valid` never dropping.
- **No timeout** (macro undefined), with `req`=16'h0006 held for 300 cycles.
  - `sel` stays at 1 throughout; `hold_cnt` saturates at 255.
- **Mid-grant reset:** pulse `rst` while `sel`=7 is granted.
  - `gnt`/`valid` are 0 on the next edge.
  - After release, arbitration restarts from index 0.
- **Mux datapath check:** the 16:1 mux is connected with `di`=16'hA5C3.
  - Whenever `valid`=1, the mux output equals `di[sel]`.

Source files
------------

// File: rtl/mux16_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux16_rr_arbiter
// Purpose  : Round-robin arbiter driving the select of a 16:1 data mux.
//            Produces a registered one-hot grant, the matching 4-bit mux
//            select and a valid flag. The search for the next winner starts
//            one position after the most recent grant and wraps modulo 16.
//            Optional hold timeout: define MUX16_ARB_TIMEOUT_EN to end a
//            grant after MAX_HOLD consecutive cycles. Without the macro a
//            grant lasts until its request drops, and MAX_HOLD has no effect.
// Ports    : clk   - clock, all state updates on the rising edge
//            rst   - synchronous active-high reset
//            req   - [15:0] request lines, held high while the mux is needed
//            gnt   - [15:0] registered one-hot grant (zero when idle)
//            sel   - [3:0]  registered mux select, index of the gnt bit
//            valid - registered, high exactly when gnt is nonzero
// Params   : MAX_HOLD - maximum consecutive grant cycles (1..255)
// Revision : 1.0 - initial release
// ============================================================================
module mux16_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    output logic [15:0] gnt,
    output logic [3:0]  sel,
    output logic        valid
);

`ifdef MUX16_ARB_TIMEOUT_EN
    localparam logic c_timeout_en = 1'b1;
`else
    localparam logic c_timeout_en = 1'b0;
`endif

    localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);
    localparam logic [7:0] c_cnt_sat  = 8'hFF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] gnt_q, gnt_d;
    logic [3:0]  sel_q, sel_d;
    logic        valid_q, valid_d;
    logic [3:0]  last_q, last_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;

    logic        w_pick_found;
    logic [3:0]  w_pick_idx;
    logic        w_timeout;
    logic        w_grant_end;

    // Rotating priority search. Offset 16 wraps back to last_q itself, so
    // a sole requester whose grant timed out wins again instead of starving.
    always_comb begin
        logic [3:0] idx;
        w_pick_found = 1'b0;
        w_pick_idx   = 4'd0;
        idx          = 4'd0;
        for (int i = 1; i <= 16; i++) begin
            idx = last_q + 4'(i);
            if (!w_pick_found && req[idx]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = idx;
            end
        end
    end

    // With the feature disabled the constant zero removes the compare.
    assign w_timeout   = c_timeout_en && (hold_cnt_q == c_max_hold);
    assign w_grant_end = !req[sel_q] || w_timeout;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        valid_d    = valid_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (w_pick_found) begin
                    state_d    = ST_BUSY;
                    gnt_d      = 16'b1 << w_pick_idx;
                    sel_d      = w_pick_idx;
                    valid_d    = 1'b1;
                    last_d     = w_pick_idx;
                    hold_cnt_d = 8'd1;
                end
            end
            ST_BUSY: begin
                if (w_grant_end) begin
                    // last_q already equals the holder, so the search
                    // naturally starts at the next requester in rotation.
                    if (w_pick_found) begin
                        gnt_d      = 16'b1 << w_pick_idx;
                        sel_d      = w_pick_idx;
                        last_d     = w_pick_idx;
                        hold_cnt_d = 8'd1;
                    end else begin
                        state_d    = ST_IDLE;
                        gnt_d      = 16'd0;
                        sel_d      = 4'd0;
                        valid_d    = 1'b0;
                        hold_cnt_d = 8'd0;
                    end
                end else if (hold_cnt_q != c_cnt_sat) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                gnt_d      = 16'd0;
                sel_d      = 4'd0;
                valid_d    = 1'b0;
                hold_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 16'd0;
            sel_q      <= 4'd0;
            valid_q    <= 1'b0;
            last_q     <= 4'd15;
            hold_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = valid_q;

endmodule
`default_nettype wire
